regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Start, input, 1 bit: request to run the program from index 0.
REQ-004 SHALL have port Abort, input, 1 bit: synchronous cancel of the running program.
REQ-005 SHALL have port Step, input, 1 bit: advance enable for instruction fetch; tie high for full speed.
REQ-006 SHALL have port Instr_Addr, output, 4 bits: program index presented to the external instruction store.
REQ-007 SHALL have port Instr_Data, input, 29 bits: {Halt[28], Dest[27:24], SrcA[23:20], SrcB[19:16], OpCode[15:0]}; combinational from Instr_Addr.
REQ-008 SHALL have port Flags, input, 5 bits: ALU flags; bit 0 is carry.
REQ-009 SHALL have ports Reg_Read_A, Reg_Read_B and Reg_Write, outputs, 4 bits each: register file addresses.
REQ-010 SHALL have port OpCode, output, 16 bits: ALU operation word.
REQ-011 SHALL have port CarryIn, output, 1 bit: stored carry fed back to the ALU.
REQ-012 SHALL have port Write_Enable, output, 1 bit: register file write strobe.
REQ-013 SHALL have ports Busy and Done, outputs, 1 bit each: run status.

Function
REQ-014 SHALL implement the states IDLE, FETCH, EXEC, WRITE and DONE.
REQ-015 SHALL keep PC as a 4-bit counter and drive Instr_Addr = PC continuously.
REQ-016 IDLE or DONE with Start=1 SHALL clear PC to 0 and enter FETCH on the next edge.
REQ-017 FETCH with Step=0 SHALL hold in FETCH.
REQ-018 FETCH with Step=1 and Halt=1 SHALL enter DONE and latch nothing.
REQ-019 FETCH with Step=1 and Halt=0 SHALL latch Instr_Data[27:0] into the instruction register and enter EXEC.
REQ-020 EXEC SHALL drive Reg_Read_A, Reg_Read_B, Reg_Write and OpCode from the latched instruction, with Write_Enable=0, for exactly one cycle (ALU settle), then enter WRITE.
REQ-021 WRITE SHALL hold the same address and opcode outputs with Write_Enable=1 for exactly one cycle.
REQ-022 WRITE SHALL capture Flags[0] into the carry register, which drives CarryIn.
REQ-023 WRITE SHALL increment PC.
REQ-024 WRITE with PC==15 SHALL enter DONE (no wrap to 0); otherwise it SHALL enter FETCH.
REQ-025 With Step held at 1, each instruction SHALL take exactly 3 cycles (FETCH, EXEC, WRITE).
REQ-026 Busy SHALL be 1 in FETCH, EXEC and WRITE, and 0 in all other states.
REQ-027 Done SHALL be 1 only in DONE, and SHALL hold until Start or Abort.
REQ-028 Start SHALL be ignored while Busy=1.
REQ-029 Abort=1 in any state SHALL enter IDLE on the next edge, with PC=0, Done=0 and the carry register cleared.
REQ-030 When Abort=1 in WRITE, that cycle's write SHALL still complete, since Write_Enable is already high; no further write SHALL be issued.
REQ-031 When Start and Abort are both 1, Abort SHALL take priority.
REQ-032 Outside EXEC and WRITE, Write_Enable SHALL be 0 and the address and OpCode outputs SHALL hold their last values.

Reset
REQ-033 RESET_n=0 SHALL immediately, independent of Clk, force the state to IDLE.
REQ-034 RESET_n=0 SHALL force PC, the instruction register, the carry register, all address outputs, OpCode, CarryIn, Write_Enable, Busy and Done to 0.
REQ-035 Reset asserted mid-instruction SHALL drop Write_Enable within the same cycle; no partial write SHALL follow deassertion.
REQ-036 After RESET_n rises, the block SHALL stay in IDLE until Start=1 is sampled.

Verification
REQ-037 Scenario: Step=1, program of 3 writes (Dest 0,1,2) with Halt at index 3, Start pulsed at edge 0 -> Write_Enable high in the cycles after edges 2, 5 and 8, with Reg_Write 0, 1, 2 respectively; Done=1 after edge 10.
REQ-038 Scenario: Step pulsed once every 4 cycles -> FETCH dwells until Step; exactly one Write_Enable pulse per Step; Busy stays 1 throughout.
REQ-039 Scenario: 16 instructions, no Halt -> 16 Write_Enable pulses; DONE entered after the write at PC=15; PC reads 0 and Instr_Addr never exceeds 15.
REQ-040 Scenario: Abort during EXEC of instruction 1 -> no Write_Enable for instruction 1; IDLE, PC=0, Busy=0 next cycle.
REQ-041 Scenario: Flags[0]=1 during WRITE of instruction 0 -> CarryIn=1 from the next cycle; Start and Abort together in DONE -> IDLE, CarryIn=0.
REQ-042 Scenario: RESET_n pulled low mid-EXEC between edges -> all outputs 0 immediately; a later Start restarts at PC=0.

Source files
------------

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - program sequencer that fetches 16 instructions and drives register-file/ALU control
module regfile_sequencer (
  input  logic        Clk,
  input  logic        RESET_n,
  input  logic        Start,
  input  logic        Abort,
  input  logic        Step,
  output logic [3:0]  Instr_Addr,
  input  logic [28:0] Instr_Data,
  input  logic [4:0]  Flags,
  output logic [3:0]  Reg_Read_A,
  output logic [3:0]  Reg_Read_B,
  output logic [3:0]  Reg_Write,
  output logic [15:0] OpCode,
  output logic        CarryIn,
  output logic        Write_Enable,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  pc;
  logic [27:0] instr_reg;
  logic        carry_reg;
  logic        halt_bit;
  logic        unused_flags;

  assign halt_bit     = Instr_Data[28];
  assign unused_flags = ^Flags[4:1];

  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (Abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (Start) state_nxt = ST_FETCH;
        ST_FETCH: begin
          if (Step) state_nxt = halt_bit ? ST_DONE : ST_EXEC;
        end
        ST_EXEC:  state_nxt = ST_WRITE;
        ST_WRITE: state_nxt = (pc == 4'd15) ? ST_DONE : ST_FETCH;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // PC wraps to 0 after the last slot; the state machine, not the PC, stops the run.
  always_ff @(posedge Clk or negedge RESET_n) begin
    if (!RESET_n) begin
      pc        <= 4'd0;
      instr_reg <= 28'd0;
      carry_reg <= 1'b0;
    end else if (Abort) begin
      pc        <= 4'd0;
      carry_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (Start) pc <= 4'd0;
        ST_FETCH: begin
          if (Step && !halt_bit) instr_reg <= Instr_Data[27:0];
        end
        ST_WRITE: begin
          pc        <= pc + 4'd1;
          carry_reg <= Flags[0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Write_Enable = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    case (state)
      ST_FETCH: Busy = 1'b1;
      ST_EXEC:  Busy = 1'b1;
      ST_WRITE: begin
        Busy         = 1'b1;
        Write_Enable = 1'b1;
      end
      ST_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  // Addresses and opcode come straight from the instruction register, which only
  // changes on a fetch, so they naturally hold between instructions.
  assign Instr_Addr = pc;
  assign Reg_Write  = instr_reg[27:24];
  assign Reg_Read_A = instr_reg[23:20];
  assign Reg_Read_B = instr_reg[19:16];
  assign OpCode     = instr_reg[15:0];
  assign CarryIn    = carry_reg;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - scoreboard bench for regfile_sequencer
module tb_regfile_sequencer;

  logic        Clk = 1'b0;
  logic        RESET_n = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic        Step = 1'b1;
  logic [3:0]  Instr_Addr;
  logic [28:0] Instr_Data;
  logic [4:0]  Flags;
  logic [3:0]  Reg_Read_A, Reg_Read_B, Reg_Write;
  logic [15:0] OpCode;
  logic        CarryIn, Write_Enable, Busy, Done;

  logic [28:0] prog [16];
  logic        flag_mem [16];
  logic [28:0] exp_q [$];
  logic [28:0] mon_e;
  logic        exp_carry = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          wr_count = 0;
  int          w0;
  int          cyc;

  regfile_sequencer dut (
    .Clk(Clk), .RESET_n(RESET_n), .Start(Start), .Abort(Abort), .Step(Step),
    .Instr_Addr(Instr_Addr), .Instr_Data(Instr_Data), .Flags(Flags),
    .Reg_Read_A(Reg_Read_A), .Reg_Read_B(Reg_Read_B), .Reg_Write(Reg_Write),
    .OpCode(OpCode), .CarryIn(CarryIn), .Write_Enable(Write_Enable),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  assign Instr_Data = prog[Instr_Addr];
  assign Flags      = {4'b0000, flag_mem[Instr_Addr]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Program slot i writes register i; halt_at >= 16 means no halt word.
  task automatic load_prog(input int halt_at);
    for (int i = 0; i < 16; i++) begin
      prog[i] = {(i == halt_at) ? 1'b1 : 1'b0, 4'(i), 4'((i + 3) % 16), 4'((i * 5) % 16),
                 16'hA000 + 16'(i * 16'h0111)};
      flag_mem[i] = 1'b0;
    end
  endtask

  task automatic push(input int i);
    exp_q.push_back({prog[i][27:24], prog[i][23:20], prog[i][19:16], prog[i][15:0], exp_carry});
    exp_carry = flag_mem[i];
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (Done !== 1'b1 && n < max) begin
      @(negedge Clk);
      n++;
    end
    if (Done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got Done=%0b after %0d cycles expected 1", Done, n);
    end
  endtask

  always @(negedge Clk) begin
    if (RESET_n && Write_Enable === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got Reg_Write=%0d expected no write", Reg_Write);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", {3'b000, Reg_Write, Reg_Read_A, Reg_Read_B, OpCode, CarryIn}, {3'b000, mon_e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    load_prog(16);
    repeat (2) @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_we", Write_Enable, 0);
    check("rst_addr", Instr_Addr, 0);
    check("rst_opcode", OpCode, 0);
    check("rst_carry", CarryIn, 0);
    RESET_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_after_reset", Busy, 0);

    // three writes, halt at 3, carry set by instructions 0 and 2
    load_prog(3);
    flag_mem[0] = 1'b1;
    flag_mem[2] = 1'b1;
    for (int i = 0; i < 3; i++) push(i);
    pulse_start();
    check("s1_busy", Busy, 1);
    for (int e = 1; e <= 11; e++) begin
      @(negedge Clk);
      check($sformatf("s1_we_e%0d", e), Write_Enable, (e == 2 || e == 5 || e == 8) ? 1 : 0);
      check($sformatf("s1_done_e%0d", e), Done, (e >= 10) ? 1 : 0);
    end
    check("s1_carry_done", CarryIn, 1);
    check("s1_addr_done", Instr_Addr, 3);
    Start = 1'b1;
    Abort = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    Abort = 1'b0;
    exp_carry = 1'b0;
    check("sa_done", Done, 0);
    check("sa_busy", Busy, 0);
    check("sa_carry", CarryIn, 0);
    check("sa_addr", Instr_Addr, 0);

    // Step pulsed every fourth cycle
    load_prog(2);
    push(0);
    push(1);
    Step = 1'b0;
    w0 = wr_count;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      repeat (3) begin
        @(negedge Clk);
        check($sformatf("s2_busy_k%0d", k), Busy, 1);
      end
      Step = 1'b1;
      @(negedge Clk);
      Step = 1'b0;
    end
    check("s2_done", Done, 1);
    check("s2_busy_end", Busy, 0);
    check("s2_writes", wr_count - w0, 2);
    Step = 1'b1;

    // sixteen instructions, no halt
    load_prog(16);
    for (int i = 0; i < 16; i++) push(i);
    w0 = wr_count;
    pulse_start();
    wait_done(60, cyc);
    check("s3_cycles", cyc, 48);
    check("s3_writes", wr_count - w0, 16);
    check("s3_pc_wrap", Instr_Addr, 0);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    exp_carry = 1'b0;

    // Abort during EXEC of instruction 1
    load_prog(3);
    push(0);
    pulse_start();
    repeat (4) @(negedge Clk);
    check("s4_exec_dest", Reg_Write, 1);
    check("s4_exec_we", Write_Enable, 0);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    exp_carry = 1'b0;
    check("s4_busy", Busy, 0);
    check("s4_pc", Instr_Addr, 0);
    check("s4_done", Done, 0);
    repeat (4) @(negedge Clk);
    check("s4_still_idle", Busy, 0);

    // Abort during WRITE of instruction 0: that write completes
    push(0);
    pulse_start();
    repeat (2) @(negedge Clk);
    check("s5_we", Write_Enable, 1);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    exp_carry = 1'b0;
    check("s5_we_after", Write_Enable, 0);
    check("s5_busy", Busy, 0);
    repeat (3) @(negedge Clk);

    // asynchronous reset between edges while in EXEC
    pulse_start();
    @(negedge Clk);
    #2;
    RESET_n = 1'b0;
    #1;
    check("s6_we", Write_Enable, 0);
    check("s6_busy", Busy, 0);
    check("s6_done", Done, 0);
    check("s6_addr", Instr_Addr, 0);
    check("s6_rda", Reg_Read_A, 0);
    check("s6_rdb", Reg_Read_B, 0);
    check("s6_wr", Reg_Write, 0);
    check("s6_op", OpCode, 0);
    check("s6_carry", CarryIn, 0);
    @(negedge Clk);
    RESET_n = 1'b1;
    exp_carry = 1'b0;
    repeat (3) @(negedge Clk);
    check("s6_idle", Busy, 0);
    for (int i = 0; i < 3; i++) push(i);
    pulse_start();
    check("s6_restart_pc", Instr_Addr, 0);
    wait_done(20, cyc);
    check("s6_cycles", cyc, 10);
    repeat (2) @(negedge Clk);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
